// File: rtl/token_boot_pkg.sv
// token_boot_pkg: FSM state encoding and the round-robin "find next enabled channel" search.
// Holds no ports. Provides state_t, sel_t and find_next(), which searches a mask of up to 64 channels.
package token_boot_pkg;

    typedef enum logic [1:0] {IDLE, XREQ, LREQ} state_t;

    localparam int MAX_CH = 64;

    typedef struct packed {
        logic [5:0] idx;
        logic       found;
        logic       wrapped;
    } sel_t;

    // The search starts at ptr (incl=1) or ptr+1 (incl=0) and wraps at n.
    // The loop runs downward so that the nearest hit is the one that is kept.
    // wrapped marks a hit that lies past the top channel.
    function automatic sel_t find_next(input logic [MAX_CH-1:0] mask, input int n,
                                       input int ptr, input logic incl);
        sel_t       r;
        int         c;
        logic [5:0] j;
        r = '0;
        for (int k = MAX_CH - 1; k >= 0; k--) begin
            c = ptr + k + (incl ? 0 : 1);
            j = 6'(c % n);
            if (k < n && mask[j]) begin
                r.idx     = j;
                r.found   = 1'b1;
                r.wrapped = (c >= n);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/token_boot_scheduler_rr_next_sel.sv
// rr_next_sel: combinational round-robin lookup of the next enabled channel.
// Ports: i_mask channel enables, i_ptr search start, i_incl include i_ptr itself,
//        o_idx selected channel, o_found any channel enabled, o_wrapped search passed the top channel.
module rr_next_sel
    import token_boot_pkg::*;
#(
    parameter int NUM_CH = 16,
    parameter int ID_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_mask,
    input  logic [ID_W-1:0]   i_ptr,
    input  logic              i_incl,
    output logic [ID_W-1:0]   o_idx,
    output logic              o_found,
    output logic              o_wrapped
);

    sel_t w_sel;

    always_comb w_sel = find_next(MAX_CH'(i_mask), NUM_CH, int'(i_ptr), i_incl);

    assign o_idx     = ID_W'(w_sel.idx);
    assign o_found   = w_sel.found;
    assign o_wrapped = w_sel.wrapped;

endmodule

// File: rtl/token_boot_scheduler.sv
// token_boot_scheduler: periodic or kicked boot round that hands out one XADC token, then logic tokens in round-robin order.
// Ports: clk, rstn (async active-low); Kick_i starts a round from IDLE; Burst_i selects burst mode;
//        ChMask_i enables channels; TokenXValid_o/TokenXReady_i is the XADC handshake;
//        TokenValid_o/TokenReady_i are the logic handshakes; ID_o is the channel pointer; Busy_o is high when not IDLE;
//        Timeout_o pulses on a logic-token abort; RoundDone_o pulses on re-entry to IDLE.
module token_boot_scheduler
    import token_boot_pkg::*;
#(
    parameter int              NUM_CH   = 16,
    parameter int              ID_W     = $clog2(NUM_CH),
    parameter longint unsigned PERIOD   = 64'd60_000_000_000,
    parameter int              PERIOD_W = 36,
    parameter int              TIMEOUT  = 0,
    parameter int              TOUT_W   = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              Kick_i,
    input  logic              Burst_i,
    input  logic [NUM_CH-1:0] ChMask_i,
    input  logic              TokenXReady_i,
    output logic              TokenXValid_o,
    input  logic [NUM_CH-1:0] TokenReady_i,
    output logic [NUM_CH-1:0] TokenValid_o,
    output logic [ID_W-1:0]   ID_o,
    output logic              Busy_o,
    output logic              Timeout_o,
    output logic              RoundDone_o
);

    state_t              r_state, w_next;
    logic [PERIOD_W-1:0] r_slack;
    logic [TOUT_W-1:0]   r_wait;
    logic [ID_W-1:0]     r_ptr, w_ptr, w_sel_idx, w_low_idx;
    logic                r_burst, r_tout, r_done;
    logic                w_sel_found, w_sel_wrap, w_low_found, w_low_wrap, w_any;
    logic                w_lready, w_abort, w_ldone;

    // In XREQ the lookup is "at or after ptr". In LREQ it is "strictly after ptr".
    rr_next_sel #(.NUM_CH(NUM_CH), .ID_W(ID_W)) u_sel (
        .i_mask(ChMask_i), .i_ptr(r_ptr), .i_incl(r_state == XREQ),
        .o_idx(w_sel_idx), .o_found(w_sel_found), .o_wrapped(w_sel_wrap)
    );

    rr_next_sel #(.NUM_CH(NUM_CH), .ID_W(ID_W)) u_low (
        .i_mask(ChMask_i), .i_ptr(ID_W'(0)), .i_incl(1'b1),
        .o_idx(w_low_idx), .o_found(w_low_found), .o_wrapped(w_low_wrap)
    );

    assign w_any    = w_low_found & ~w_low_wrap;
    assign w_lready = TokenReady_i[r_ptr];
    // An abort happens only when ready is absent, so a same-cycle ready counts as a completion.
    assign w_abort  = (TIMEOUT > 0) && r_state == LREQ && !w_lready && r_wait == TOUT_W'(TIMEOUT - 1);
    assign w_ldone  = r_state == LREQ && (w_lready || w_abort);

    always_comb begin
        w_next = r_state;
        w_ptr  = r_ptr;
        case (r_state)
            IDLE: w_next = (Kick_i || r_slack == PERIOD_W'(PERIOD - 1)) ? XREQ : IDLE;
            XREQ: if (TokenXReady_i) begin
                w_next = w_any ? LREQ : IDLE;
                w_ptr  = !w_any ? r_ptr : Burst_i ? w_low_idx : w_sel_idx;
            end
            LREQ: if (w_ldone) begin
                if (r_burst && w_sel_found && !w_sel_wrap) begin
                    w_ptr = w_sel_idx;
                end else begin
                    w_next = IDLE;
                    w_ptr  = r_burst ? w_low_idx : w_sel_found ? w_sel_idx : r_ptr;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_slack <= '0;
            r_wait  <= '0;
            r_burst <= 1'b0;
            r_tout  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ptr   <= w_ptr;
            r_slack <= (r_state == IDLE && w_next == IDLE) ? r_slack + 1'b1 : '0;
            // The wait counter restarts from zero for every token, including back-to-back burst tokens.
            r_wait  <= (r_state == LREQ && !w_ldone) ? r_wait + 1'b1 : '0;
            r_burst <= (r_state == XREQ && TokenXReady_i) ? Burst_i : r_burst;
            r_tout  <= w_abort;
            r_done  <= r_state != IDLE && w_next == IDLE;
        end
    end

    assign TokenXValid_o = r_state == XREQ;
    assign TokenValid_o  = (r_state == LREQ) ? (NUM_CH'(1) << r_ptr) : '0;
    assign ID_o          = r_ptr;
    assign Busy_o        = r_state != IDLE;
    assign Timeout_o     = r_tout;
    assign RoundDone_o   = r_done;

endmodule
